branch_resolver: RTL and testbench

ID-stage branch resolution controller for the MIPS/DLX pipeline. It sequences the instruction-decode equality comparison for BEQ/BNE, including hazard stalling, MEM-stage operand forwarding, PC redirect and IF/ID squash. It sits beside the register file and between the hazard unit and the PC mux. Every branch costs one stall cycle, plus one squashed slot when taken.

---
 rtl/branch_resolver.sv | 103 ++++++++++
 tb/tb_branch_resolver.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// branch_resolver: ID-stage BEQ/BNE resolution with hazard stall, MEM forwarding and redirect/squash.
// Optional taken/branch counters when BRANCH_STATS_EN is defined.
module branch_resolver #(
   parameter int BUS_SIZE = 32,
   parameter int REG_ADDR = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_valid,
   input  logic                id_is_beq,
   input  logic                id_is_bne,
   input  logic [REG_ADDR-1:0] id_rs,
   input  logic [REG_ADDR-1:0] id_rt,
   input  logic [BUS_SIZE-1:0] id_rs_data,
   input  logic [BUS_SIZE-1:0] id_rt_data,
   input  logic                ex_reg_write,
   input  logic                ex_mem_read,
   input  logic [REG_ADDR-1:0] ex_rd,
   input  logic                mem_reg_write,
   input  logic                mem_mem_read,
   input  logic [REG_ADDR-1:0] mem_rd,
   input  logic [BUS_SIZE-1:0] mem_alu_result,
   output logic                stall,
   output logic                pc_src,
   output logic                flush_if,
   output logic                branch_done
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0]         taken_count,
   output logic [15:0]         branch_count
`endif
);
   typedef enum logic [1:0] {IDLE, WAIT, EVAL} state_t;
   state_t state_q, state_d;
   logic [BUS_SIZE-1:0] opa_q, opa_d, opb_q, opb_d;
   logic bne_q, bne_d;
   logic branch, haz_rs, haz_rt, hazard, capture, taken, ex_load;
   logic [BUS_SIZE-1:0] fwd_rs, fwd_rt;
   assign ex_load = ex_mem_read;
   assign branch = id_valid & (id_is_beq | id_is_bne);
   // a load in EX is already covered by ex_reg_write; ex_mem_read only matters once it reaches MEM
   assign haz_rs = (|id_rs) & ((ex_reg_write & (ex_rd == id_rs)) |
                   (mem_mem_read & mem_reg_write & (mem_rd == id_rs)));
   assign haz_rt = (|id_rt) & ((ex_reg_write & (ex_rd == id_rt)) |
                   (mem_mem_read & mem_reg_write & (mem_rd == id_rt)));
   assign hazard = haz_rs | haz_rt;
   assign fwd_rs = (mem_reg_write & ~mem_mem_read & (mem_rd == id_rs) & (|id_rs)) ? mem_alu_result : id_rs_data;
   assign fwd_rt = (mem_reg_write & ~mem_mem_read & (mem_rd == id_rt) & (|id_rt)) ? mem_alu_result : id_rt_data;
   assign taken = (opa_q == opb_q) ^ bne_q;
   assign pc_src = (state_q == EVAL) & taken;
   assign flush_if = pc_src;
   assign branch_done = state_q == EVAL;
   always_comb begin
      state_d = IDLE;
      stall = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            stall = branch;
            capture = branch & ~hazard;
            state_d = branch ? (hazard ? WAIT : EVAL) : IDLE;
         end
         WAIT: begin
            stall = 1'b1;
            capture = id_valid & ~hazard;
            state_d = ~id_valid ? IDLE : (hazard ? WAIT : EVAL);
         end
         default: state_d = IDLE;
      endcase
      opa_d = capture ? fwd_rs : opa_q;
      opb_d = capture ? fwd_rt : opb_q;
      bne_d = capture ? id_is_bne : bne_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         opa_q <= '0;
         opb_q <= '0;
         bne_q <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q <= opa_d;
         opb_q <= opb_d;
         bne_q <= bne_d;
      end
   end
`ifdef BRANCH_STATS_EN
   logic [15:0] taken_cnt_q, branch_cnt_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         taken_cnt_q <= '0;
         branch_cnt_q <= '0;
      end else if (state_q == EVAL) begin
         branch_cnt_q <= branch_cnt_q + 16'd1;
         taken_cnt_q <= taken_cnt_q + {15'd0, taken};
      end
   end
   assign taken_count = taken_cnt_q;
   assign branch_count = branch_cnt_q;
`endif
   logic unused;
   assign unused = ex_load;
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: table-driven single-branch vectors plus hand sequences for stalls, forwarding and reset.
module tb_branch_resolver;
   logic clk = 1'b0;
   logic rst_n, id_valid, id_is_beq, id_is_bne;
   logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
   logic [31:0] id_rs_data, id_rt_data, mem_alu_result;
   logic ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read;
   logic stall, pc_src, flush_if, branch_done;
`ifdef BRANCH_STATS_EN
   logic [15:0] taken_count, branch_count;
`endif
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   branch_resolver #(.BUS_SIZE(32), .REG_ADDR(5)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_is_beq(id_is_beq), .id_is_bne(id_is_bne),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
      .mem_alu_result(mem_alu_result), .stall(stall), .pc_src(pc_src), .flush_if(flush_if),
      .branch_done(branch_done)
`ifdef BRANCH_STATS_EN
      , .taken_count(taken_count), .branch_count(branch_count)
`endif
   );
   typedef struct {
      string nm;
      logic v, beq, bne;
      logic [4:0] rs, rt;
      logic [31:0] rsd, rtd;
      logic exw, exr;
      logic [4:0] exrd;
      logic mw, mr;
      logic [4:0] mrd;
      logic [31:0] malu;
      logic st, dn, tk;
   } vec_t;
   vec_t vt[14];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   task automatic clear_in();
      id_valid = 1'b0; id_is_beq = 1'b0; id_is_bne = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
      id_rs_data = 32'h0; id_rt_data = 32'h0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
      mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = 5'd0; mem_alu_result = 32'h0;
   endtask
   task automatic branch_in(input logic bne, input logic [31:0] a, input logic [31:0] b);
      id_valid = 1'b1; id_is_beq = ~bne; id_is_bne = bne; id_rs = 5'd3; id_rt = 5'd4;
      id_rs_data = a; id_rt_data = b;
   endtask
   task automatic run_vec(input vec_t x);
      @(negedge clk);
      id_valid = x.v; id_is_beq = x.beq; id_is_bne = x.bne; id_rs = x.rs; id_rt = x.rt;
      id_rs_data = x.rsd; id_rt_data = x.rtd; ex_reg_write = x.exw; ex_mem_read = x.exr; ex_rd = x.exrd;
      mem_reg_write = x.mw; mem_mem_read = x.mr; mem_rd = x.mrd; mem_alu_result = x.malu;
      #1 chk({x.nm, "_stall0"}, 32'(stall), 32'(x.st));
      @(negedge clk);
      clear_in();
      #1;
      chk({x.nm, "_done"}, 32'(branch_done), 32'(x.dn));
      chk({x.nm, "_pc_src"}, 32'(pc_src), 32'(x.tk));
      chk({x.nm, "_flush"}, 32'(flush_if), 32'(x.tk));
      chk({x.nm, "_stall1"}, 32'(stall), 32'(1'b0));
      @(negedge clk);
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clear_in();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask
   initial begin
      vt[0]  = '{"beq_eq",  1'b1,1'b1,1'b0,5'd3,5'd4,32'h5,32'h5,1'b0,1'b0,5'd0,1'b0,1'b0,5'd0,32'h0,1'b1,1'b1,1'b1};
      vt[1]  = '{"bne_eq",  1'b1,1'b0,1'b1,5'd3,5'd4,32'h5,32'h5,1'b0,1'b0,5'd0,1'b0,1'b0,5'd0,32'h0,1'b1,1'b1,1'b0};
      vt[2]  = '{"beq_ne",  1'b1,1'b1,1'b0,5'd3,5'd4,32'h5,32'h6,1'b0,1'b0,5'd0,1'b0,1'b0,5'd0,32'h0,1'b1,1'b1,1'b0};
      vt[3]  = '{"bne_ne",  1'b1,1'b0,1'b1,5'd3,5'd4,32'h5,32'h6,1'b0,1'b0,5'd0,1'b0,1'b0,5'd0,32'h0,1'b1,1'b1,1'b1};
      vt[4]  = '{"beq_r0",  1'b1,1'b1,1'b0,5'd0,5'd0,32'h0,32'h0,1'b1,1'b0,5'd0,1'b1,1'b1,5'd0,32'h9,1'b1,1'b1,1'b1};
      vt[5]  = '{"nonbr",   1'b1,1'b0,1'b0,5'd3,5'd4,32'h5,32'h5,1'b0,1'b0,5'd0,1'b0,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0};
      vt[6]  = '{"invalid", 1'b0,1'b1,1'b0,5'd3,5'd4,32'h5,32'h5,1'b0,1'b0,5'd0,1'b0,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0};
      vt[7]  = '{"beq_msb", 1'b1,1'b1,1'b0,5'd3,5'd4,32'hFFFF_FFFF,32'h7FFF_FFFF,1'b0,1'b0,5'd0,1'b0,1'b0,5'd0,32'h0,1'b1,1'b1,1'b0};
      vt[8]  = '{"bne_msb", 1'b1,1'b0,1'b1,5'd3,5'd4,32'h8000_0000,32'h0,1'b0,1'b0,5'd0,1'b0,1'b0,5'd0,32'h0,1'b1,1'b1,1'b1};
      vt[9]  = '{"ex_other",1'b1,1'b1,1'b0,5'd3,5'd4,32'h5,32'h5,1'b1,1'b0,5'd5,1'b0,1'b0,5'd0,32'h0,1'b1,1'b1,1'b1};
      vt[10] = '{"fwd_rs",  1'b1,1'b1,1'b0,5'd3,5'd4,32'h1,32'h5,1'b0,1'b0,5'd0,1'b1,1'b0,5'd3,32'h5,1'b1,1'b1,1'b1};
      vt[11] = '{"fwd_rt",  1'b1,1'b0,1'b1,5'd3,5'd4,32'h5,32'h5,1'b0,1'b0,5'd0,1'b1,1'b0,5'd4,32'h6,1'b1,1'b1,1'b1};
      vt[12] = '{"ex_nowr", 1'b1,1'b1,1'b0,5'd3,5'd4,32'h5,32'h5,1'b0,1'b1,5'd3,1'b0,1'b0,5'd0,32'h0,1'b1,1'b1,1'b1};
      vt[13] = '{"mem_nowr",1'b1,1'b1,1'b0,5'd3,5'd4,32'h5,32'h5,1'b0,1'b0,5'd0,1'b0,1'b1,5'd3,32'h9,1'b1,1'b1,1'b1};
      clear_in();
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_pc_src", 32'(pc_src), 32'd0);
      chk("rst_flush", 32'(flush_if), 32'd0);
      chk("rst_done", 32'(branch_done), 32'd0);
      for (int i = 0; i < 14; i++) run_vec(vt[i]);
      // ALU producer of r3 in EX, result forwarded from MEM the next cycle
      @(negedge clk);
      branch_in(1'b0, 32'h1, 32'h5); ex_reg_write = 1'b1; ex_rd = 5'd3;
      #1 chk("alu_ex_stall0", 32'(stall), 32'd1);
      @(negedge clk);
      ex_reg_write = 1'b0; ex_rd = 5'd0; mem_reg_write = 1'b1; mem_rd = 5'd3; mem_alu_result = 32'h5;
      #1 chk("alu_ex_stall1", 32'(stall), 32'd1);
      chk("alu_ex_done1", 32'(branch_done), 32'd0);
      @(negedge clk);
      clear_in();
      #1 chk("alu_ex_done", 32'(branch_done), 32'd1);
      chk("alu_ex_taken", 32'(pc_src), 32'd1);
      chk("alu_ex_stall2", 32'(stall), 32'd0);
      @(negedge clk);
      // load to r4: stale regfile value until WB
      @(negedge clk);
      branch_in(1'b0, 32'h7, 32'h0); ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4;
      #1 chk("ld_stall0", 32'(stall), 32'd1);
      @(negedge clk);
      ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
      mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd4; mem_alu_result = 32'hDEAD;
      #1 chk("ld_stall1", 32'(stall), 32'd1);
      chk("ld_done1", 32'(branch_done), 32'd0);
      @(negedge clk);
      mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_rd = 5'd0; id_rt_data = 32'h7;
      #1 chk("ld_stall2", 32'(stall), 32'd1);
      chk("ld_done2", 32'(branch_done), 32'd0);
      @(negedge clk);
      clear_in();
      #1 chk("ld_done", 32'(branch_done), 32'd1);
      chk("ld_taken", 32'(pc_src), 32'd1);
      chk("ld_stall3", 32'(stall), 32'd0);
      @(negedge clk);
      // reset while waiting drops the branch
      @(negedge clk);
      branch_in(1'b0, 32'h7, 32'h7); ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4;
      @(negedge clk);
      ex_reg_write = 1'b0; ex_mem_read = 1'b0; mem_reg_write = 1'b1; mem_mem_read = 1'b1; mem_rd = 5'd4;
      rst_n = 1'b0;
      #1 chk("rw_wait_stall", 32'(stall), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      clear_in();
      #1 chk("rw_stall", 32'(stall), 32'd0);
      chk("rw_pc_src", 32'(pc_src), 32'd0);
      chk("rw_flush", 32'(flush_if), 32'd0);
      chk("rw_done", 32'(branch_done), 32'd0);
      @(negedge clk);
      #1 chk("rw_pc_src2", 32'(pc_src), 32'd0);
      chk("rw_done2", 32'(branch_done), 32'd0);
      // id_valid drops while waiting: no resolution
      @(negedge clk);
      branch_in(1'b0, 32'h5, 32'h5); ex_reg_write = 1'b1; ex_rd = 5'd3;
      @(negedge clk);
      clear_in();
      #1 chk("drop_stall", 32'(stall), 32'd1);
      @(negedge clk);
      #1 chk("drop_done", 32'(branch_done), 32'd0);
      chk("drop_pc_src", 32'(pc_src), 32'd0);
      chk("drop_stall2", 32'(stall), 32'd0);
`ifdef BRANCH_STATS_EN
      do_reset();
      chk("cnt_rst_taken", 32'(taken_count), 32'd0);
      chk("cnt_rst_branch", 32'(branch_count), 32'd0);
      run_vec(vt[0]); run_vec(vt[1]); run_vec(vt[3]); run_vec(vt[2]); run_vec(vt[4]);
      chk("cnt_taken", 32'(taken_count), 32'd3);
      chk("cnt_branch", 32'(branch_count), 32'd5);
      do_reset();
      chk("cnt_clr_taken", 32'(taken_count), 32'd0);
      chk("cnt_clr_branch", 32'(branch_count), 32'd0);
`else
      do_reset();
      chk("final_done", 32'(branch_done), 32'd0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
